// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//
// Memory-mapped 8N1 UART transmitter for the single-cycle RISC-V core's
// data bus. The core stores bytes into TXDATA; they are queued in a small
// circular FIFO and shifted out LSB first on tx, framed by a start bit and
// a stop bit. Each bit lasts BAUDDIV clock cycles.
//
// Register map (word offset on addr):
//   0 TXDATA  write pushes wdata[7:0]; reads as 0
//   1 STATUS  bit0 tx_active, bit1 fifo_full, bit2 fifo_empty,
//             bit3 overflow (sticky), bits[11:8] fifo count;
//             a write with wdata[3]=1 clears overflow
//   2 BAUDDIV clk cycles per bit, bits[DIV_WIDTH-1:0]; 0 is stored as 1
//   3 reserved
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low
//   sel    block selected by the top-level address decode
//   we     store strobe
//   addr   word offset within the 16-byte window
//   wdata  store data
//   rdata  combinational load data (0 when sel is low)
//   tx     registered serial output, idle high
//   busy   frame on the wire or FIFO non-empty

module mmio_uart_tx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Registered state
  state_t               state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [DIV_WIDTH-1:0] frame_div_q, frame_div_d;
  logic [DIV_WIDTH-1:0] baud_div_q, baud_div_d;
  logic                 tx_q, tx_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           mem_q [FIFO_DEPTH];

  // Decoded bus strobes and FIFO status
  logic        wr_txdata, wr_status, wr_bauddiv;
  logic        fifo_full, fifo_empty;
  logic        push, pop;
  logic        tx_active;
  logic        baud_done;
  logic [7:0]  fifo_head;
  logic [31:0] status_word;
  logic        unused_wdata;

  assign wr_txdata  = sel & we & (addr == 2'd0);
  assign wr_status  = sel & we & (addr == 2'd1);
  assign wr_bauddiv = sel & we & (addr == 2'd2);

  // Full is judged on the count before this cycle's pop, so a push into a
  // full FIFO is dropped even when a pop frees a slot in the same cycle.
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = wr_txdata & ~fifo_full;
  assign fifo_head  = mem_q[rd_ptr_q];

  assign tx_active  = (state_q != IDLE);
  assign baud_done  = (baud_cnt_q == frame_div_q - DIV_WIDTH'(1));

  assign tx   = tx_q;
  assign busy = tx_active | ~fifo_empty;

  assign status_word = {20'd0, 4'(count_q), 4'd0,
                        overflow_q, fifo_empty, fifo_full, tx_active};

  // Only the low byte and the divider field of wdata are ever used.
  assign unused_wdata = ^wdata;

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        2'd1:    rdata = status_word;
        2'd2:    rdata[DIV_WIDTH-1:0] = baud_div_q;
        default: rdata = '0;
      endcase
    end
  end

  // Register-file next state: divider and sticky overflow flag.
  always_comb begin
    baud_div_d = baud_div_q;
    overflow_d = overflow_q;
    if (wr_bauddiv) begin
      // A zero divider would make the baud counter never terminate.
      if (wdata[DIV_WIDTH-1:0] == '0) begin
        baud_div_d = DIV_WIDTH'(1);
      end else begin
        baud_div_d = wdata[DIV_WIDTH-1:0];
      end
    end
    if (wr_status && wdata[3]) begin
      overflow_d = 1'b0;
    end
    if (wr_txdata && fifo_full) begin
      overflow_d = 1'b1;
    end
  end

  // Transmitter next state. tx_d is derived from the state being entered so
  // that tx is a registered output that changes on the same edge as state.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    baud_cnt_d  = baud_cnt_q;
    shift_d     = shift_q;
    frame_div_d = frame_div_q;
    tx_d        = tx_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_d     = fifo_head;
          frame_div_d = baud_div_q;
          baud_cnt_d  = '0;
          state_d     = START;
          tx_d        = 1'b0;
        end
      end

      START: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          bit_cnt_d  = 3'd0;
          state_d    = DATA;
          tx_d       = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
        end
      end

      STOP: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          // Chain straight into the next frame with no idle bit time.
          if (!fifo_empty) begin
            pop         = 1'b1;
            shift_d     = fifo_head;
            frame_div_d = baud_div_q;
            state_d     = START;
            tx_d        = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      baud_cnt_q  <= '0;
      shift_q     <= 8'd0;
      frame_div_q <= DIV_WIDTH'(DEFAULT_DIV);
      baud_div_q  <= DIV_WIDTH'(DEFAULT_DIV);
      tx_q        <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      baud_cnt_q  <= baud_cnt_d;
      shift_q     <= shift_d;
      frame_div_q <= frame_div_d;
      baud_div_q  <= baud_div_d;
      tx_q        <= tx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_q[wr_ptr_q] <= wdata[7:0];
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
//
// Self-checking bench for mmio_uart_tx: a table of single-cycle register
// accesses followed by hand-written multi-cycle frame sequences.

module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .FIFO_DEPTH (8),
    .DIV_WIDTH  (16),
    .DEFAULT_DIV(434)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sel  (sel),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .tx   (tx),
    .busy (busy)
  );

  typedef struct {
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_busy;
    logic        exp_tx;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic s, input logic w, input logic [1:0] a,
                         input logic [31:0] d, input logic [31:0] er,
                         input logic eb, input logic et, input string n);
    vec_t v;
    v.sel = s; v.we = w; v.addr = a; v.wdata = d;
    v.exp_rdata = er; v.exp_busy = eb; v.exp_tx = et; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Advance one clock; leave the bus idle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    sel = 1'b0;
    we  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    step();
  endtask

  task automatic bus_read_check(input logic [1:0] a, input logic [31:0] exp,
                                input string name);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    check_output(name, rdata, exp);
    sel = 1'b0;
  endtask

  function automatic logic [31:0] status_word(input logic act, input logic full,
                                              input logic empty, input logic ovf,
                                              input logic [3:0] cnt);
    return {20'd0, cnt, 4'd0, ovf, empty, full, act};
  endfunction

  // Expected tx level for one bit slot: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic frame_bit(input logic [7:0] data, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return data[idx-1];
  endfunction

  // Checks tx for cycles first..10*div-1 of a frame, one step per cycle.
  task automatic check_frame(input logic [7:0] data, input int div,
                             input int first, input string name);
    for (int k = first; k < 10 * div; k++) begin
      step();
      check_output(name, {31'd0, tx}, {31'd0, frame_bit(data, k / div)});
    end
  endtask

  task automatic apply_stimulus(input int i);
    sel = vecs[i].sel; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
    #1;
    check_output({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
    check_output({vecs[i].name, "_busy"}, {31'd0, busy}, {31'd0, vecs[i].exp_busy});
    check_output({vecs[i].name, "_tx"}, {31'd0, tx}, {31'd0, vecs[i].exp_tx});
    step();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;

    // Register-level vectors, each applied for one cycle from reset.
    add_vec(1, 0, 2'd1, 32'h0,        32'h0000_0004, 0, 1, "status_reset");
    add_vec(1, 0, 2'd2, 32'h0,        32'h0000_01B2, 0, 1, "bauddiv_reset");
    add_vec(0, 0, 2'd2, 32'h0,        32'h0000_0000, 0, 1, "sel_low_read");
    add_vec(1, 0, 2'd3, 32'h0,        32'h0000_0000, 0, 1, "reserved_read");
    add_vec(1, 0, 2'd0, 32'h0,        32'h0000_0000, 0, 1, "txdata_read");
    add_vec(1, 1, 2'd2, 32'h7,        32'h0000_01B2, 0, 1, "bauddiv_wr7");
    add_vec(1, 0, 2'd2, 32'h0,        32'h0000_0007, 0, 1, "bauddiv_rd7");
    add_vec(1, 1, 2'd2, 32'h0,        32'h0000_0007, 0, 1, "bauddiv_wr0");
    add_vec(1, 0, 2'd2, 32'h0,        32'h0000_0001, 0, 1, "bauddiv_zero_is_one");
    add_vec(1, 1, 2'd2, 32'hFFFF_1234, 32'h0000_0001, 0, 1, "bauddiv_wr_wide");
    add_vec(1, 0, 2'd2, 32'h0,        32'h0000_1234, 0, 1, "bauddiv_truncated");
    add_vec(1, 1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1, "reserved_write");
    add_vec(1, 0, 2'd2, 32'h0,        32'h0000_1234, 0, 1, "after_reserved_div");
    add_vec(1, 0, 2'd1, 32'h0,        32'h0000_0004, 0, 1, "after_reserved_status");
    add_vec(0, 1, 2'd0, 32'h55,       32'h0000_0000, 0, 1, "unselected_push");
    add_vec(1, 0, 2'd1, 32'h0,        32'h0000_0004, 0, 1, "no_push");
    add_vec(1, 1, 2'd1, 32'hFFFF_FFFF, 32'h0000_0004, 0, 1, "status_write");
    add_vec(1, 0, 2'd1, 32'h0,        32'h0000_0004, 0, 1, "status_unchanged");

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(i);
    end

    // Single 0x55 frame at 4 cycles per bit.
    do_reset();
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h55);
    check_output("a_tx_idle_after_write", {31'd0, tx}, 32'd1);
    check_output("a_busy_after_write", {31'd0, busy}, 32'd1);
    bus_read_check(2'd1, status_word(0, 0, 0, 0, 4'd1), "a_status_queued");
    check_frame(8'h55, 4, 0, "a_frame_tx");
    check_output("a_busy_in_stop", {31'd0, busy}, 32'd1);
    step();
    check_output("a_busy_done", {31'd0, busy}, 32'd0);
    check_output("a_tx_done", {31'd0, tx}, 32'd1);
    bus_read_check(2'd1, 32'h0000_0004, "a_status_done");

    // Two back-to-back frames at 2 cycles per bit.
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'hA3);
    bus_write(2'd0, 32'h0F);
    check_output("b_start_first", {31'd0, tx}, 32'd0);
    bus_read_check(2'd1, status_word(1, 0, 0, 0, 4'd1), "b_status_one_queued");
    check_frame(8'hA3, 2, 1, "b_frame1_tx");
    check_frame(8'h0F, 2, 0, "b_frame2_tx");
    step();
    check_output("b_busy_done", {31'd0, busy}, 32'd0);

    // Fill the FIFO, overflow it, then clear the sticky flag.
    bus_write(2'd2, 32'd100);
    for (int i = 0; i < 8; i++) begin
      bus_write(2'd0, 32'(i));
    end
    bus_read_check(2'd1, status_word(1, 0, 0, 0, 4'd7), "c_status_count7");
    bus_write(2'd0, 32'h8);
    bus_read_check(2'd1, status_word(1, 1, 0, 0, 4'd8), "c_status_full");
    bus_write(2'd0, 32'h9);
    bus_read_check(2'd1, status_word(1, 1, 0, 1, 4'd8), "c_status_overflow");
    bus_write(2'd1, 32'hFFFF_FFF7);
    bus_read_check(2'd1, status_word(1, 1, 0, 1, 4'd8), "c_overflow_sticky");
    bus_write(2'd1, 32'h8);
    bus_read_check(2'd1, status_word(1, 1, 0, 0, 4'd8), "c_overflow_cleared");
    do_reset();
    bus_read_check(2'd1, 32'h0000_0004, "c_status_after_reset");
    check_output("c_tx_after_reset", {31'd0, tx}, 32'd1);

    // Divider 0 becomes 1; then a mid-frame divider change.
    bus_write(2'd2, 32'd0);
    bus_read_check(2'd2, 32'd1, "d_div_reads_one");
    bus_write(2'd0, 32'h3C);
    check_frame(8'h3C, 1, 0, "d_frame_div1");
    step();
    check_output("d_busy_after_short", {31'd0, busy}, 32'd0);
    bus_write(2'd0, 32'h81);
    bus_write(2'd0, 32'h42);
    check_output("d_start_first", {31'd0, tx}, 32'd0);
    sel = 1'b1; we = 1'b1; addr = 2'd2; wdata = 32'd8;
    check_frame(8'h81, 1, 1, "d_frame_old_div");
    check_frame(8'h42, 8, 0, "d_frame_new_div");
    step();
    check_output("d_busy_done", {31'd0, busy}, 32'd0);
    bus_read_check(2'd2, 32'd8, "d_div_reads_eight");

    // Reset during data bit 3 aborts the frame and drops the queued byte.
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'hF0);
    bus_write(2'd0, 32'h11);
    for (int i = 0; i < 16; i++) begin
      step();
    end
    check_output("e_tx_bit3", {31'd0, tx}, 32'd0);
    bus_read_check(2'd1, status_word(1, 0, 0, 0, 4'd1), "e_status_mid_frame");
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_output("e_tx_after_reset", {31'd0, tx}, 32'd1);
    check_output("e_busy_after_reset", {31'd0, busy}, 32'd0);
    bus_read_check(2'd1, 32'h0000_0004, "e_status_after_reset");
    bus_read_check(2'd2, 32'd434, "e_div_after_reset");
    for (int i = 0; i < 4; i++) begin
      step();
      check_output("e_tx_stays_idle", {31'd0, tx}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
